cut_scheduler: RTL and testbench

- Sequences and shares the single cutting driver (cut_controller) between two requesters, e.g. the recipe FSM and the manual-button unit.
- Each granted job is N full cut strokes. Every stroke is a cut_i/cut_end handshake with cut_controller, and a conveyor feed interval separates consecutive strokes.
- Sits between the top-level controller unit and cut_controller. The conveyor motor driver consumes feed_o.

---
 rtl/cut_pkg.sv | 25 ++
 rtl/rr_arbiter2.sv | 34 +++
 rtl/cut_scheduler.sv | 173 +++++++++++++++++
 tb/tb_cut_scheduler.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cut_pkg.sv
// Shared definitions for the cut scheduler: state encoding, clock rate and
// helpers that turn millisecond settings into clock-cycle counts.
package cut_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CUT  = 2'd1,
        S_FEED = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // 50 MHz system clock
    localparam int unsigned CLK_PER_MS = 50000;

    // Converts a duration in ms into a 32-bit cycle count
    function automatic logic [31:0] ms_to_cycles(input int unsigned ms, input int unsigned per_ms);
        return 32'(ms * per_ms);
    endfunction

    localparam int unsigned FEED_MS_DEF    = 20;
    localparam int unsigned TIMEOUT_MS_DEF = 5000;
    localparam logic [31:0] FEED_CYC_DEF   = ms_to_cycles(FEED_MS_DEF, CLK_PER_MS);
    localparam logic [31:0] WD_CYC_DEF     = ms_to_cycles(TIMEOUT_MS_DEF, CLK_PER_MS);

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. The pointer names the requester preferred when
// both ask; it is moved to the other requester whenever upd is pulsed.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic [1:0] served,
    output logic [1:0] gnt
);

    logic ptr;

    // Pointer moves away from the requester that was just served
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (upd) begin
            ptr <= served[0];
        end
    end

    // One-hot grant: a lone request always wins, a tie goes to the pointer
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/cut_scheduler.sv
// Shares the single cut_controller between two requesters. Each granted job
// runs N cut strokes separated by conveyor feed intervals.
// Optional stroke watchdog enabled with the CUT_WATCHDOG_EN macro.
module cut_scheduler
    import cut_pkg::*;
#(
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned FEED_MS    = 20,
    parameter int unsigned TIMEOUT_MS = 5000,
    // Clock cycles per ms; lowered only for scaled-down simulation
    parameter int unsigned CYC_PER_MS = CLK_PER_MS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_i,
    input  logic [CNT_W-1:0] cnt0_i,
    input  logic [CNT_W-1:0] cnt1_i,
    input  logic             abort_i,
    output logic [1:0]       gnt_o,
    output logic [1:0]       done_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] remain_o,
    output logic             cut_o,
    input  logic             cut_end_i,
    output logic             feed_o,
    output logic             err_o
);

    localparam logic [31:0] FEED_CYC = ms_to_cycles(FEED_MS, CYC_PER_MS);

    state_t           state;
    logic [1:0]       gnt;
    logic [1:0]       done;
    logic             busy;
    logic [CNT_W-1:0] remain;
    logic             cut;
    logic             feed;
    logic             abort_pend;
    logic [31:0]      feed_cnt;
    logic [1:0]       arb_gnt;
    logic [CNT_W-1:0] grant_cnt;
    logic             wd_expire;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_i),
        .upd    (state == S_DONE),
        .served (gnt),
        .gnt    (arb_gnt)
    );

    assign grant_cnt = arb_gnt[1] ? cnt1_i : cnt0_i;

`ifdef CUT_WATCHDOG_EN
    localparam logic [31:0] WD_CYC = ms_to_cycles(TIMEOUT_MS, CYC_PER_MS);

    logic [31:0] wd_cnt;
    logic        err;

    // Stroke watchdog: held at zero outside CUT, so each stroke starts fresh
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (state != S_CUT) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 32'd1;
        end
    end

    assign wd_expire = (state == S_CUT) && (wd_cnt == WD_CYC - 32'd1);

    // Sticky error flag, cleared by the next grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (state == S_IDLE && |req_i) begin
            err <= 1'b0;
        end else if (wd_expire && !cut_end_i) begin
            err <= 1'b1;
        end
    end

    assign err_o = err;
`else
    assign wd_expire = 1'b0;
    assign err_o     = 1'b0;
`endif

    // Job sequencer: grant, stroke/feed loop, completion pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            gnt        <= '0;
            done       <= '0;
            busy       <= 1'b0;
            remain     <= '0;
            cut        <= 1'b0;
            feed       <= 1'b0;
            abort_pend <= 1'b0;
            feed_cnt   <= '0;
        end else begin
            done <= '0;
            case (state)
                S_IDLE: begin
                    if (|req_i) begin
                        gnt        <= arb_gnt;
                        busy       <= 1'b1;
                        remain     <= grant_cnt;
                        abort_pend <= 1'b0;
                        if (grant_cnt == '0) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_CUT;
                            cut   <= 1'b1;
                        end
                    end
                end
                S_CUT: begin
                    if (abort_i) begin
                        abort_pend <= 1'b1;
                    end
                    if (cut_end_i) begin
                        cut <= 1'b0;
                        if (remain != '0) begin
                            remain <= remain - CNT_W'(1);
                        end
                        // Stroke finished: stop if it was the last one or an abort arrived
                        if (remain <= CNT_W'(1) || abort_pend || abort_i) begin
                            state <= S_DONE;
                        end else begin
                            state    <= S_FEED;
                            feed     <= 1'b1;
                            feed_cnt <= '0;
                        end
                    end else if (wd_expire) begin
                        cut   <= 1'b0;
                        state <= S_DONE;
                    end
                end
                S_FEED: begin
                    if (abort_i) begin
                        feed  <= 1'b0;
                        state <= S_DONE;
                    end else if (feed_cnt == FEED_CYC - 32'd1) begin
                        feed  <= 1'b0;
                        cut   <= 1'b1;
                        state <= S_CUT;
                    end else begin
                        feed_cnt <= feed_cnt + 32'd1;
                    end
                end
                S_DONE: begin
                    done       <= gnt;
                    gnt        <= '0;
                    busy       <= 1'b0;
                    abort_pend <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign gnt_o    = gnt;
    assign done_o   = done;
    assign busy_o   = busy;
    assign remain_o = remain;
    assign cut_o    = cut;
    assign feed_o   = feed;

endmodule

// File: tb/tb_cut_scheduler.sv
// Directed testbench for cut_scheduler, run with a scaled clock-per-ms so a
// feed interval is 10 cycles and the watchdog limit is 5 cycles.
module tb_cut_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req = 2'b00;
    logic [3:0] cnt0 = 4'd0;
    logic [3:0] cnt1 = 4'd0;
    logic       abort = 1'b0;
    logic       cut_end = 1'b0;
    logic [1:0] gnt_o, done_o;
    logic       busy_o, cut_o, feed_o, err_o;
    logic [3:0] remain_o;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    cut_scheduler #(.CNT_W(4), .FEED_MS(2), .TIMEOUT_MS(1), .CYC_PER_MS(5)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .cnt0_i(cnt0), .cnt1_i(cnt1),
        .abort_i(abort), .gnt_o(gnt_o), .done_o(done_o), .busy_o(busy_o),
        .remain_o(remain_o), .cut_o(cut_o), .cut_end_i(cut_end),
        .feed_o(feed_o), .err_o(err_o)
    );

    task automatic step;
        @(negedge clk);
    endtask

    // Answer an active stroke: cut_end pulse 'delay+1' cycles after cut rose
    task automatic stroke(input int delay);
        repeat (delay) step;
        cut_end = 1'b1;
        step;
        cut_end = 1'b0;
    endtask

    // Count cycles with feed_o high (bounded)
    task automatic feed_len(output int n);
        n = 0;
        while (feed_o === 1'b1 && n < 100) begin
            n++;
            step;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step; step;
        vectors++; if ({gnt_o, done_o, busy_o, remain_o, cut_o, feed_o, err_o} !== 12'd0) begin errors++; $display("FAIL reset_outputs: got %h expected 000", {gnt_o, done_o, busy_o, remain_o, cut_o, feed_o, err_o}); end
        rst_n = 1'b1;
        step;
        vectors++; if (busy_o !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy_o); end
        $display("reset: outputs=%h", {gnt_o, done_o, busy_o, remain_o, cut_o, feed_o, err_o});
    endtask

    task automatic test_round_robin;
        req = 2'b11; cnt0 = 4'd1; cnt1 = 4'd1;
        step;
        vectors++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL rr_first: got %b expected 01", gnt_o); end
        stroke(3);
        step;
        vectors++; if (done_o !== 2'b01) begin errors++; $display("FAIL rr_done0: got %b expected 01", done_o); end
        step;
        vectors++; if (gnt_o !== 2'b10) begin errors++; $display("FAIL rr_second: got %b expected 10", gnt_o); end
        vectors++; if (remain_o !== 4'd1) begin errors++; $display("FAIL rr_remain1: got %0d expected 1", remain_o); end
        stroke(3);
        step;
        vectors++; if (done_o !== 2'b10) begin errors++; $display("FAIL rr_done1: got %b expected 10", done_o); end
        cnt0 = 4'd0;
        step;
        vectors++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL rr_third: got %b expected 01", gnt_o); end
        req = 2'b00;
        step;
        vectors++; if (done_o !== 2'b01) begin errors++; $display("FAIL rr_done2: got %b expected 01", done_o); end
        step;
        $display("round_robin: served 0,1,0");
    endtask

    task automatic test_basic;
        int n;
        logic [3:0] exp_rem;
        cnt0 = 4'd3; req = 2'b01;
        step;
        req = 2'b00;
        vectors++; if ({gnt_o, busy_o, cut_o} !== 4'b0111) begin errors++; $display("FAIL basic_grant: got gnt=%b busy=%b cut=%b expected 01 1 1", gnt_o, busy_o, cut_o); end
        for (int k = 0; k < 3; k++) begin
            exp_rem = 4'(3 - k);
            vectors++; if (remain_o !== exp_rem) begin errors++; $display("FAIL basic_remain_pre%0d: got %0d expected %0d", k, remain_o, exp_rem); end
            vectors++; if (cut_o !== 1'b1) begin errors++; $display("FAIL basic_cut_hi%0d: got %b expected 1", k, cut_o); end
            stroke(3);
            exp_rem = 4'(2 - k);
            vectors++; if ({cut_o, remain_o} !== {1'b0, exp_rem}) begin errors++; $display("FAIL basic_post%0d: got cut=%b rem=%0d expected 0 %0d", k, cut_o, remain_o, exp_rem); end
            if (k < 2) begin
                vectors++; if (feed_o !== 1'b1) begin errors++; $display("FAIL basic_feed_on%0d: got %b expected 1", k, feed_o); end
                feed_len(n);
                vectors++; if (n != 10) begin errors++; $display("FAIL basic_feed_len%0d: got %0d expected 10", k, n); end
            end else begin
                vectors++; if ({feed_o, done_o, busy_o} !== 4'b0001) begin errors++; $display("FAIL basic_last: got feed=%b done=%b busy=%b expected 0 00 1", feed_o, done_o, busy_o); end
            end
            $display("basic: stroke %0d remain=%0d", k, remain_o);
        end
        step;
        vectors++; if ({done_o, gnt_o, busy_o, err_o} !== 6'b010000) begin errors++; $display("FAIL basic_done: got done=%b gnt=%b busy=%b err=%b expected 01 00 0 0", done_o, gnt_o, busy_o, err_o); end
        step;
        vectors++; if (done_o !== 2'b00) begin errors++; $display("FAIL basic_done_width: got %b expected 00", done_o); end
    endtask

    task automatic test_zero_count;
        cnt0 = 4'd0; req = 2'b01;
        step;
        req = 2'b00;
        vectors++; if ({gnt_o, busy_o, cut_o, feed_o, done_o} !== 7'b0110000) begin errors++; $display("FAIL zero_grant: got %b expected 0110000", {gnt_o, busy_o, cut_o, feed_o, done_o}); end
        step;
        vectors++; if ({done_o, busy_o, cut_o} !== 4'b0100) begin errors++; $display("FAIL zero_done: got %b expected 0100", {done_o, busy_o, cut_o}); end
        step;
        $display("zero_count: done pulse seen");
    endtask

    task automatic test_abort;
        int n;
        cnt0 = 4'd5; req = 2'b01;
        step;
        req = 2'b00;
        stroke(3);
        vectors++; if ({feed_o, remain_o} !== {1'b1, 4'd4}) begin errors++; $display("FAIL abort_feed: got feed=%b rem=%0d expected 1 4", feed_o, remain_o); end
        cut_end = 1'b1;
        step;
        cut_end = 1'b0;
        vectors++; if ({feed_o, remain_o} !== {1'b1, 4'd4}) begin errors++; $display("FAIL stray_cut_end: got feed=%b rem=%0d expected 1 4", feed_o, remain_o); end
        feed_len(n);
        vectors++; if (cut_o !== 1'b1) begin errors++; $display("FAIL abort_stroke2: got %b expected 1", cut_o); end
        step;
        abort = 1'b1;
        step;
        abort = 1'b0;
        vectors++; if ({cut_o, feed_o} !== 2'b10) begin errors++; $display("FAIL abort_hold: got cut=%b feed=%b expected 1 0", cut_o, feed_o); end
        stroke(1);
        vectors++; if ({cut_o, feed_o, remain_o} !== {2'b00, 4'd3}) begin errors++; $display("FAIL abort_end: got cut=%b feed=%b rem=%0d expected 0 0 3", cut_o, feed_o, remain_o); end
        step;
        vectors++; if ({done_o, remain_o} !== {2'b01, 4'd3}) begin errors++; $display("FAIL abort_done: got done=%b rem=%0d expected 01 3", done_o, remain_o); end
        step;
        $display("abort: finished with remain=%0d", remain_o);
    endtask

    task automatic test_reset_mid;
        int n;
        cnt0 = 4'd3; req = 2'b01;
        step;
        req = 2'b00;
        stroke(3);
        feed_len(n);
        vectors++; if (cut_o !== 1'b1) begin errors++; $display("FAIL rmid_stroke2: got %b expected 1", cut_o); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if ({gnt_o, done_o, busy_o, remain_o, cut_o, feed_o} !== 11'd0) begin errors++; $display("FAIL rmid_async: got %h expected 000", {gnt_o, done_o, busy_o, remain_o, cut_o, feed_o}); end
        step;
        rst_n = 1'b1;
        step;
        req = 2'b11; cnt0 = 4'd0; cnt1 = 4'd0;
        step;
        vectors++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL rmid_ptr: got %b expected 01", gnt_o); end
        req = 2'b00;
        step; step;
        $display("reset_mid: pointer back at requester 0");
    endtask

`ifdef CUT_WATCHDOG_EN
    task automatic test_watchdog;
        int n;
        cnt0 = 4'd1; req = 2'b01;
        step;
        req = 2'b00;
        vectors++; if ({cut_o, err_o} !== 2'b10) begin errors++; $display("FAIL wd_start: got cut=%b err=%b expected 1 0", cut_o, err_o); end
        n = 0;
        while (cut_o === 1'b1 && n < 100) begin
            n++;
            step;
        end
        vectors++; if (n != 5) begin errors++; $display("FAIL wd_len: got %0d expected 5", n); end
        vectors++; if (err_o !== 1'b1) begin errors++; $display("FAIL wd_err: got %b expected 1", err_o); end
        step;
        vectors++; if ({done_o, err_o} !== 3'b011) begin errors++; $display("FAIL wd_done: got done=%b err=%b expected 01 1", done_o, err_o); end
        step;
        $display("watchdog: expired after %0d cycles", n);
    endtask
`endif

    initial begin
        test_reset;
        test_round_robin;
        test_basic;
        test_zero_count;
        test_abort;
        test_reset_mid;
`ifdef CUT_WATCHDOG_EN
        test_watchdog;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
